// File: rtl/sysu_pkg.sv
// Shared sysu library definitions: synchronizer depth, level-sampler FSM
// state encoding and the stability counter width.
package sysu_pkg;

  // Flops in the metastability synchronizer ahead of any qualification logic.
  localparam int SYNC_DEPTH = 2;

  // Stability counter width; covers STABLE_CYCLES up to 65535.
  localparam int STAB_W = 16;

  // Level-sampler FSM encoding.
  localparam logic [1:0] ST_STABLE_LO = 2'd0;
  localparam logic [1:0] ST_CHK_HI    = 2'd1;
  localparam logic [1:0] ST_STABLE_HI = 2'd2;
  localparam logic [1:0] ST_CHK_LO    = 2'd3;

  typedef enum logic [1:0] {
    STABLE_LO = ST_STABLE_LO,
    CHK_HI    = ST_CHK_HI,
    STABLE_HI = ST_STABLE_HI,
    CHK_LO    = ST_CHK_LO
  } lvl_state_e;

endpackage

// File: rtl/sysu_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sysu_sync2
  import sysu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] ff;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      // NOTE: non-blocking, so each stage captures its predecessor's value
      // from before the edge; blocking would collapse the chain to one flop.
      ff <= {ff[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = ff[SYNC_DEPTH-1];

endmodule

// File: rtl/sysu_level_sampler.sv
// Debounced level sampler: synchronizes level_in, accepts a new level only
// after STABLE_CYCLES identical samples, pulses rise/fall on each accepted
// change and counts accepted edges in a wrapping counter.
module sysu_level_sampler
  import sysu_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             level_in,
  input  logic             clr_cnt,
  output logic             level_out,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt
);

  // Counter value on the last qualifying sample; the counter never exceeds it.
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  logic              sync;
  lvl_state_e        state;
  logic [STAB_W-1:0] stab_cnt;

  sysu_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (level_in),
    .q     (sync)
  );

  // Qualification FSM with registered level_out and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STABLE_LO;
      stab_cnt  <= '0;
      level_out <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      // Pulses default low and are only raised on the accepting edge.
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (sync) begin
            state    <= CHK_HI;
            stab_cnt <= STAB_W'(1);
          end
        end
        CHK_HI: begin
          if (!sync) begin
            state    <= STABLE_LO;
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state     <= STABLE_HI;
            stab_cnt  <= '0;
            level_out <= 1'b1;
            rise      <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end
        STABLE_HI: begin
          if (!sync) begin
            state    <= CHK_LO;
            stab_cnt <= STAB_W'(1);
          end
        end
        CHK_LO: begin
          if (sync) begin
            state    <= STABLE_HI;
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state     <= STABLE_LO;
            stab_cnt  <= '0;
            level_out <= 1'b0;
            fall      <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end
        default: begin
          state    <= STABLE_LO;
          stab_cnt <= '0;
        end
      endcase
    end
  end

  // Count accepted edges; a clear wins over an edge pulse in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (clr_cnt) begin
      edge_cnt <= '0;
    end else if (rise || fall) begin
      edge_cnt <= edge_cnt + CNT_W'(1);
    end
  end

endmodule
